lifo_arbiter: RTL
=================

Name: lifo_arbiter

Overview:
- Shares one 8-bit-wide stack between two requesters using a round-robin grant, one operation per cycle.
- The stack storage is built in, along with per-requester response and error signalling.
- Sits between two producer/consumer agents and replaces direct wn/rn driving of a stand-alone LIFO.
- Push and pop are serialised. Illegal operations (push when full, pop when empty) are granted but rejected with an error pulse, so a requester never deadlocks.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 8: number of stack entries.
- CW, 4: count width; must satisfy 2**CW > DEPTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; bit i belongs to requester i.
- op  in  2  per-requester operation: 1 = push, 0 = pop. Sampled only while req[i] = 1.
- wdata0  in  WIDTH  push data from requester 0.
- wdata1  in  WIDTH  push data from requester 1.
- grant  out  2  one-hot (or zero). Combinational from req and the arbitration pointer.
- rsp_valid  out  2  one-cycle pulse, registered; pop data valid for requester i.
- rsp_data  out  WIDTH  popped data, registered, shared by both requesters.
- err  out  2  one-cycle pulse, registered; requester i's granted op was rejected.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  number of occupied entries.

Behaviour:
- Reset (synchronous, active-high):
  - count = 0, last = 1 (requester 0 has priority first), rsp_valid = 0, err = 0, rsp_data = 0, full = 0, empty = 1.
  - grant is forced to 0 while reset = 1.
  - Memory contents are not cleared and are don't-care.
- Arbitration:
  - Only req = 01 -> grant = 01; only req = 10 -> grant = 10.
  - req = 11 -> grant the requester != last.
  - req = 00 -> grant = 00 and last is unchanged.
  - On any grant, last <= granted index at the clock edge.
- Request protocol:
  - A requester holds req, op and wdata stable until it sees grant[i] = 1 in the same cycle.
  - The op executes at the rising edge that ends that cycle.
  - If req is dropped before grant, the request is abandoned with no side effects.
- Granted push:
  - If count < DEPTH: mem[count] <= wdata_i; count <= count + 1.
  - Else: no write, count unchanged, err[i] = 1 in the next cycle.
- Granted pop:
  - If count > 0: rsp_data <= mem[count-1]; count <= count - 1; rsp_valid[i] = 1 in the next cycle.
  - Else: count unchanged, rsp_data holds, err[i] = 1 in the next cycle.
- Latency:
  - Grant is 0 cycles after req.
  - Pop data and error are 1 cycle after grant.
  - A requester may re-request in the cycle after its grant.
  - Back-to-back grants to the same requester are allowed when the other requester is idle.
- Pulse width: rsp_valid and err are each high for exactly one cycle per granted op. rsp_valid and err are never both high for the same requester.
- rsp_data holds its last value when rsp_valid = 0.
- Flags: full, empty and count are derived from registered count, reflect state after the last edge, and never go stale.
- Simultaneous events: exactly one op is executed per cycle. The losing requester keeps req high and is granted next cycle (fairness bound: 1 cycle of wait).
- Reset mid-operation: a grant in the reset cycle is suppressed. A rsp_valid or err pending for the following cycle is cleared (both outputs read 0 after reset).
- Count never wraps: saturation is enforced by the reject rules above.

Decomposition:
- Shared package lifo_pkg:
  - OP_PUSH = 1'b1, OP_POP = 1'b0.
  - Default WIDTH and DEPTH constants.
- One sub-module: lifo_rr_arb2 (2-way round-robin arbiter; inputs req, last; output one-hot grant).
- Stack storage and pointer logic stay in lifo_arbiter.

Test Plan:
1. Reset then idle -> empty = 1, full = 0, count = 0, grant = 00, rsp_valid = 00, err = 00.
2. Requester 0 pushes 8'h11, 8'h22, 8'h33 on consecutive cycles, then pops three times -> rsp_valid[0] pulses with rsp_data 8'h33, 8'h22, 8'h11, each one cycle after its grant; empty = 1 at the end.
3. req = 11 held with both pushing (r0 data 8'hA0, r1 data 8'hB0) for 4 cycles -> grants 01, 10, 01, 10; count = 4; stack top = 8'hB0.
4. Fill to count = 8 (full = 1), then one more push from r1 -> grant[1] = 1, err[1] pulses 1 cycle later, count stays 8, contents unchanged (next pop returns the 8th pushed value).
5. Pop from r0 while empty -> err[0] = 1 for one cycle, rsp_valid = 00, count stays 0, rsp_data unchanged.
6. Assert reset in the same cycle as a granted pop with count = 3 -> grant forced 00, next cycle count = 0, empty = 1, rsp_valid = 00, last = 1 (a subsequent req = 11 grants r0 first).

Source files
------------

// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
// Shared constants for the two-requester arbitrated stack.
//   OP_PUSH / OP_POP : encoding of a requester's op bit
//   DEF_WIDTH        : default data width
//   DEF_DEPTH        : default number of stack entries
//   DEF_CW           : default count width (2**DEF_CW must exceed DEF_DEPTH)
// -----------------------------------------------------------------------------
package lifo_pkg;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CW    = 4;

endpackage : lifo_pkg

// File: rtl/lifo_rr_arb2.sv
// -----------------------------------------------------------------------------
// lifo_rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req   in  2  request bits, bit i belongs to requester i
//   last  in  1  index of the requester granted most recently
//   grant out 2  one-hot grant, or zero when nobody requests
// -----------------------------------------------------------------------------
module lifo_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the requester that was not
  // served most recently wins, so a waiting requester never waits > 1 cycle.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule : lifo_rr_arb2

// File: rtl/lifo_arbiter.sv
// -----------------------------------------------------------------------------
// lifo_arbiter
// One stack shared by two requesters, one granted push or pop per cycle.
// Illegal ops (push when full, pop when empty) are still granted but answered
// with an err pulse instead of touching the stack.
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   req        in   2      per-requester request
//   op         in   2      per-requester op (1 = push, 0 = pop)
//   wdata0     in   WIDTH  push data of requester 0
//   wdata1     in   WIDTH  push data of requester 1
//   grant      out  2      combinational one-hot grant (0 during reset)
//   rsp_valid  out  2      registered pulse: pop data valid for requester i
//   rsp_data   out  WIDTH  registered popped data, held between pops
//   err        out  2      registered pulse: requester i's op was rejected
//   full       out  1      count == DEPTH
//   empty      out  1      count == 0
//   count      out  CW     occupied entries
// -----------------------------------------------------------------------------
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       grant,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       err,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             last;
  logic [1:0]       arb_grant;
  logic             sel;
  logic             sel_op;
  logic [WIDTH-1:0] sel_wdata;
  logic             granted;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  lifo_rr_arb2 u_arb (
    .req   (req),
    .last  (last),
    .grant (arb_grant)
  );

  // Reset suppresses any grant so no op is acknowledged in the reset cycle.
  assign grant     = reset ? 2'b00 : arb_grant;
  assign granted   = |grant;
  assign sel       = grant[1];
  assign sel_op    = op[sel];
  assign sel_wdata = sel ? wdata1 : wdata0;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign do_push = granted && (sel_op == OP_PUSH) && !full;
  assign do_pop  = granted && (sel_op == OP_POP)  && !empty;

  // Low bits of count address the next free slot; when count == DEPTH for a
  // power-of-two depth the low bits wrap to 0, so decrementing them still
  // lands on the top entry.
  assign wr_idx = count[AW-1:0];
  assign rd_idx = count[AW-1:0] - AW'(1);

  // Storage is deliberately left out of reset; stale entries are never read
  // because count bounds every access.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_idx] <= sel_wdata;
    end
  end

  // Control state: count, round-robin pointer and the one-cycle response
  // pulses. Pulses default low every cycle so each granted op yields exactly
  // one rsp_valid or err pulse, never both.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      last      <= 1'b1;
      rsp_valid <= 2'b00;
      err       <= 2'b00;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 2'b00;
      err       <= 2'b00;
      if (granted) begin
        last <= sel;
        if (sel_op == OP_PUSH) begin
          if (do_push) begin
            count <= count + CW'(1);
          end else begin
            err[sel] <= 1'b1;
          end
        end else begin
          if (do_pop) begin
            rsp_data       <= mem[rd_idx];
            count          <= count - CW'(1);
            rsp_valid[sel] <= 1'b1;
          end else begin
            err[sel] <= 1'b1;
          end
        end
      end
    end
  end

endmodule : lifo_arbiter
